regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
- Shares the single register-file write port between two writeback requesters.
- Requester A is the main pipeline writeback path and has priority. Requester B is a multi-cycle source such as a load completion or a long-latency ALU operation.
- Fixed priority to A, with a starvation guard that forces one B grant after B has waited MAX_WAIT cycles.
- Outputs are registered and drive the register file's write_address / write_data / write_enable directly.

Parameters:
- DATA_SIZE, 32, width of write data.
- GPR_SIZE, 3, width of register address.
- MAX_WAIT, 4, consecutive blocked cycles for B before B is forced to win; legal range 1..255.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- a_valid  input  1  A has a write pending.
- a_address  input  GPR_SIZE  A destination register.
- a_data  input  DATA_SIZE  A write data.
- a_ready  output  1  A write accepted this cycle (combinational).
- b_valid  input  1  B has a write pending.
- b_address  input  GPR_SIZE  B destination register.
- b_data  input  DATA_SIZE  B write data.
- b_ready  output  1  B write accepted this cycle (combinational).
- write_address  output  GPR_SIZE  to register file (registered).
- write_data  output  DATA_SIZE  to register file (registered).
- write_enable  output  1  to register file (registered).
- grant_b  output  1  registered; 1 when the current write_enable came from B.

Behaviour:
- Handshake:
  - A transfer occurs when valid && ready are both high at a rising edge.
  - A requester holds valid, address and data stable until accepted.
  - At most one transfer per cycle.
- State machine, two states:
  - A_PRIO (reset state):
    - a_ready = 1.
    - b_ready = !a_valid.
  - B_PRIO:
    - b_ready = 1.
    - a_ready = !b_valid.
- Starvation counter wait_cnt (8 bits), reset 0:
  - In A_PRIO, wait_cnt increments when b_valid && a_valid (B blocked).
  - It clears to 0 when B is accepted, or when b_valid is 0.
  - If B is blocked and wait_cnt == MAX_WAIT-1, the next state is B_PRIO and wait_cnt clears.
- B_PRIO lasts exactly one cycle; the next state is always A_PRIO.
  - If b_valid is 0 in B_PRIO (protocol violation), A is served normally and the state still returns to A_PRIO.
- Output register:
  - On the edge where a transfer occurs, capture the winner's address and data into write_address / write_data.
  - On that edge, set write_enable = 1 and grant_b = (winner is B).
  - If there is no transfer: write_enable = 0, write_address = 0, write_data = 0, grant_b = 0.
  - Zeroed outputs when idle are mandatory, not don't-care.
- Latency: a request accepted at edge N appears on the write port during the cycle after edge N. Exactly one write_enable pulse per accepted request.
- Simultaneous A and B requests:
  - A wins in A_PRIO; B wins in B_PRIO.
  - The loser sees ready = 0 and retries.
- A same-cycle A and B request to the same register needs no special handling; the writes are serialized in grant order.
- Register address 0 is not filtered; it is forwarded like any other address.
- Reset (synchronous, active-high):
  - state = A_PRIO, wait_cnt = 0.
  - write_enable = 0, write_address = 0, write_data = 0, grant_b = 0.
  - a_ready and b_ready are forced to 0 while reset is high.
  - Reset asserted mid-operation discards any un-accepted request; no write is issued on the cycle after reset.
- Ready outputs depend combinationally on the valid inputs only, never on the ready inputs of the other side, so there are no combinational loops.

Test Plan:
- After reset, only a_valid is high with address 5 and data 0x1234 -> a_ready=1 same cycle; next cycle write_enable=1, write_address=5, write_data=0x1234, grant_b=0; the cycle after that, all outputs are 0.
- Only b_valid is high with address 2 and data 0xCAFE -> b_ready=1 immediately; next cycle the write port shows address 2, data 0xCAFE, grant_b=1.
- A and B both valid for one cycle -> A is granted first and B is granted the following cycle. Expect two consecutive write_enable pulses, A's then B's.
- MAX_WAIT=4, A valid continuously and B valid continuously:
  - A is granted for 4 cycles.
  - Then B is granted once (b_ready=1, a_ready=0 in the 5th cycle).
  - Then A resumes; the pattern repeats every 5 cycles.
- B blocked for 2 cycles, then b_valid drops -> wait_cnt clears. A later 3-cycle block does not trigger B_PRIO prematurely: it takes the full 4 blocked cycles.
- Reset asserted while B is blocked with wait_cnt=3 -> the next cycle has write_enable=0, both readies 0 during reset, and the state is A_PRIO with wait_cnt=0 afterwards.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Shares one register-file write port between a priority writeback path (A) and a
// multi-cycle source (B). After B has been blocked MAX_WAIT cycles it is forced to win once.
module regfile_write_arbiter #(
    parameter int DATA_SIZE = 32,
    parameter int GPR_SIZE  = 3,
    parameter int MAX_WAIT  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 a_valid,
    input  logic [GPR_SIZE-1:0]  a_address,
    input  logic [DATA_SIZE-1:0] a_data,
    output logic                 a_ready,
    input  logic                 b_valid,
    input  logic [GPR_SIZE-1:0]  b_address,
    input  logic [DATA_SIZE-1:0] b_data,
    output logic                 b_ready,
    output logic [GPR_SIZE-1:0]  write_address,
    output logic [DATA_SIZE-1:0] write_data,
    output logic                 write_enable,
    output logic                 grant_b
);

    // state  | meaning
    // A_PRIO | A always ready; B ready only when A is idle
    // B_PRIO | one-cycle starvation override; B always ready
    typedef enum logic {
        A_PRIO = 1'b0,
        B_PRIO = 1'b1
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t     state;
    state_t     state_next;
    logic [7:0] wait_cnt;
    logic [7:0] wait_cnt_next;
    logic       a_fire;
    logic       b_fire;
    logic       b_blocked;

    assign a_fire    = a_valid && a_ready;
    assign b_fire    = b_valid && b_ready;
    assign b_blocked = (state == A_PRIO) && a_valid && b_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= A_PRIO;
            wait_cnt <= 8'd0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    // Anything other than a blocked B in A_PRIO clears the counter and returns to A_PRIO.
    always_comb begin
        state_next    = A_PRIO;
        wait_cnt_next = 8'd0;
        if (b_blocked) begin
            if (wait_cnt == WAIT_LAST) begin
                state_next = B_PRIO;
            end else begin
                wait_cnt_next = wait_cnt + 8'd1;
            end
        end
    end

    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        if (!reset) begin
            unique case (state)
                A_PRIO: begin
                    a_ready = 1'b1;
                    b_ready = !a_valid;
                end
                B_PRIO: begin
                    a_ready = !b_valid;
                    b_ready = 1'b1;
                end
            endcase
        end
    end

    // Idle cycles drive zeros onto the write port, not stale data.
    always_ff @(posedge clk) begin
        if (reset) begin
            write_enable  <= 1'b0;
            write_address <= '0;
            write_data    <= '0;
            grant_b       <= 1'b0;
        end else if (a_fire) begin
            write_enable  <= 1'b1;
            write_address <= a_address;
            write_data    <= a_data;
            grant_b       <= 1'b0;
        end else if (b_fire) begin
            write_enable  <= 1'b1;
            write_address <= b_address;
            write_data    <= b_data;
            grant_b       <= 1'b1;
        end else begin
            write_enable  <= 1'b0;
            write_address <= '0;
            write_data    <= '0;
            grant_b       <= 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed-vector bench for regfile_write_arbiter: stimulus pushes expected writes into a
// queue, a negedge monitor pops and compares every write-port cycle.
module tb_regfile_write_arbiter;

    typedef struct {
        logic [2:0]  addr;
        logic [31:0] data;
        logic        gb;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_valid;
    logic [2:0]  a_address;
    logic [31:0] a_data;
    logic        a_ready;
    logic        b_valid;
    logic [2:0]  b_address;
    logic [31:0] b_data;
    logic        b_ready;
    logic [2:0]  write_address;
    logic [31:0] write_data;
    logic        write_enable;
    logic        grant_b;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  cyc_no   = 0;
    bit  mon_en   = 1'b0;

    regfile_write_arbiter #(.DATA_SIZE(32), .GPR_SIZE(3), .MAX_WAIT(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .a_valid      (a_valid),
        .a_address    (a_address),
        .a_data       (a_data),
        .a_ready      (a_ready),
        .b_valid      (b_valid),
        .b_address    (b_address),
        .b_data       (b_data),
        .b_ready      (b_ready),
        .write_address(write_address),
        .write_data   (write_data),
        .write_enable (write_enable),
        .grant_b      (grant_b)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mon_en) begin
            wr_t e;
            n_checks++;
            if (write_enable) begin
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_write t=%0t: got we=1 addr=%0d data=%h gb=%b, required no write",
                             $time, write_address, write_data, grant_b);
                end else begin
                    e = exp_q.pop_front();
                    if (write_address !== e.addr || write_data !== e.data || grant_b !== e.gb) begin
                        n_fail++;
                        $display("FAIL write_port t=%0t: got addr=%0d data=%h gb=%b, required addr=%0d data=%h gb=%b",
                                 $time, write_address, write_data, grant_b, e.addr, e.data, e.gb);
                    end
                end
            end else if (write_enable !== 1'b0 || write_address !== 3'd0 ||
                         write_data !== 32'd0 || grant_b !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_zero t=%0t: got we=%b addr=%0d data=%h gb=%b, required all zero",
                         $time, write_enable, write_address, write_data, grant_b);
            end
        end
    end

    // win: 0 = no transfer, 1 = A accepted, 2 = B accepted
    task automatic cyc(input logic r, input logic av, input logic [2:0] aa, input logic [31:0] ad,
                       input logic bv, input logic [2:0] ba, input logic [31:0] bd,
                       input logic ear, input logic ebr, input int win);
        wr_t e;
        @(posedge clk);
        #1;
        reset     = r;
        a_valid   = av;
        a_address = aa;
        a_data    = ad;
        b_valid   = bv;
        b_address = ba;
        b_data    = bd;
        #1;
        cyc_no++;
        n_checks++;
        if (a_ready !== ear || b_ready !== ebr) begin
            n_fail++;
            $display("FAIL readies cycle %0d: got a_ready=%b b_ready=%b, required a_ready=%b b_ready=%b",
                     cyc_no, a_ready, b_ready, ear, ebr);
        end
        if (win == 1) begin
            e.addr = aa; e.data = ad; e.gb = 1'b0;
            exp_q.push_back(e);
        end else if (win == 2) begin
            e.addr = ba; e.data = bd; e.gb = 1'b1;
            exp_q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    endtask

    initial begin
        int ka;
        int kb;
        bit bw;
        reset = 1'b1; a_valid = 0; a_address = 0; a_data = 0;
        b_valid = 0; b_address = 0; b_data = 0;
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        mon_en = 1'b1;
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // single A, then idle port must be zero
        cyc(0, 1, 3'd5, 32'h1234, 0, 0, 0, 1, 0, 1);
        idle(2);
        // single B
        cyc(0, 0, 0, 0, 1, 3'd2, 32'hCAFE, 1, 1, 2);
        idle(1);
        // simultaneous A/B: A first, B next cycle
        cyc(0, 1, 3'd1, 32'h11, 1, 3'd3, 32'h33, 1, 0, 1);
        cyc(0, 0, 0, 0, 1, 3'd3, 32'h33, 1, 1, 2);
        idle(1);

        // continuous contention: 4 A grants then one forced B grant, twice
        ka = 0; kb = 0;
        for (int i = 0; i < 10; i++) begin
            bw = (i % 5 == 4);
            cyc(0, 1, 3'(ka % 8), 32'h100 + 32'(ka), 1, 3'd6, 32'hB00 + 32'(kb),
                !bw, bw, bw ? 2 : 1);
            if (bw) kb++; else ka++;
        end
        idle(1);

        // 2 blocked cycles, B drops (counter clears), then a full 4-cycle block is needed
        cyc(0, 1, 3'd0, 32'hA0, 1, 3'd7, 32'hB7, 1, 0, 1);
        cyc(0, 1, 3'd1, 32'hA1, 1, 3'd7, 32'hB7, 1, 0, 1);
        cyc(0, 1, 3'd2, 32'hA2, 0, 0, 0, 1, 0, 1);
        cyc(0, 1, 3'd3, 32'hA3, 1, 3'd4, 32'hB4, 1, 0, 1);
        cyc(0, 1, 3'd4, 32'hA4, 1, 3'd4, 32'hB4, 1, 0, 1);
        cyc(0, 1, 3'd5, 32'hA5, 1, 3'd4, 32'hB4, 1, 0, 1);
        cyc(0, 1, 3'd6, 32'hA6, 1, 3'd4, 32'hB4, 1, 0, 1);
        cyc(0, 1, 3'd7, 32'hA7, 1, 3'd4, 32'hB4, 0, 1, 2);
        idle(1);

        // reset with wait_cnt = 3 pending; afterwards the counter restarts from 0
        cyc(0, 1, 3'd1, 32'hC1, 1, 3'd2, 32'hD2, 1, 0, 1);
        cyc(0, 1, 3'd1, 32'hC2, 1, 3'd2, 32'hD2, 1, 0, 1);
        cyc(0, 1, 3'd1, 32'hC3, 1, 3'd2, 32'hD2, 1, 0, 1);
        cyc(1, 1, 3'd1, 32'hC4, 1, 3'd2, 32'hD2, 0, 0, 0);
        cyc(0, 1, 3'd1, 32'hC4, 1, 3'd2, 32'hD2, 1, 0, 1);
        cyc(0, 1, 3'd1, 32'hC5, 1, 3'd2, 32'hD2, 1, 0, 1);
        cyc(0, 1, 3'd1, 32'hC6, 1, 3'd2, 32'hD2, 1, 0, 1);
        cyc(0, 1, 3'd1, 32'hC7, 1, 3'd2, 32'hD2, 1, 0, 1);
        cyc(0, 1, 3'd1, 32'hC8, 1, 3'd2, 32'hD2, 0, 1, 2);
        idle(3);

        @(posedge clk);
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL missing_writes: got %0d expected writes still pending, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
